// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and RX deframer state encoding.
// No logic; constants only.
// Used by both the RX deframer and the TX framer.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
  // Bit-reversed form of 0x04C11DB7 for the LSB-first shift.
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    WAIT_END
  } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 next-state for one byte, LSB first, no final inversion.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC/length/rx_er, emits 8-bit AXIS.
// Latency: pin byte to tdata 7 cycles; first dv=0 on pins to tlast/status 2 cycles.
// Backpressure: none; no tready, the sink must take every beat.
module gmii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1522
) (
  input  logic       clock125,
  input  logic       reset,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] rx_axis_tdata,
  output logic       rx_axis_tvalid,
  output logic       rx_axis_tlast,
  output logic       rx_axis_tuser,
  output logic       rx_error_bad_frame,
  output logic       rx_error_bad_fcs,
  output logic       rx_good_frame
);

  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LENGTH);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LENGTH);

  logic [7:0]       rxd_q;
  logic             dv_q;
  logic             er_q;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic [10:0]      cnt;
  logic             er_seen;
  logic [3:0][7:0]  win;
  logic [7:0]       pend;
  logic             frame_start;
  logic             byte_acc;
  logic             frame_end;
  logic             pend_vld;
  logic             fcs_bad;
  logic             bad;

  // dv resets high so a frame already in flight at reset release is skipped via WAIT_END.
  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      rxd_q <= 8'h00;
      dv_q  <= 1'b1;
      er_q  <= 1'b0;
    end else begin
      rxd_q <= gmii_rxd;
      dv_q  <= gmii_rx_dv;
      er_q  <= gmii_rx_er;
    end
  end

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dv_q) begin
          if (rxd_q == ETH_PREAMBLE) state_nxt = PREAMBLE;
          else if (rxd_q == ETH_SFD) state_nxt = PAYLOAD;
          else                       state_nxt = WAIT_END;
        end
      end
      PREAMBLE: begin
        if (!dv_q)                      state_nxt = IDLE;
        else if (rxd_q == ETH_SFD)      state_nxt = PAYLOAD;
        else if (rxd_q != ETH_PREAMBLE) state_nxt = WAIT_END;
      end
      PAYLOAD:  if (!dv_q) state_nxt = IDLE;
      WAIT_END: if (!dv_q) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign frame_start = (state != PAYLOAD) && (state_nxt == PAYLOAD);
  assign byte_acc    = (state == PAYLOAD) && dv_q;
  assign frame_end   = (state == PAYLOAD) && !dv_q;
  // Pending holds a byte once five have arrived: four sit in the FCS window.
  assign pend_vld    = (cnt >= 11'd5);
  assign fcs_bad     = (crc != CRC32_RESIDUE);
  assign bad         = er_seen || (cnt < MIN_LEN) || (cnt > MAX_LEN) || fcs_bad || !pend_vld;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (rxd_q),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge clock125 or posedge reset) begin
    if (reset) begin
      crc                <= CRC32_INIT;
      cnt                <= 11'd0;
      er_seen            <= 1'b0;
      win                <= '0;
      pend               <= 8'h00;
      rx_axis_tdata      <= 8'h00;
      rx_axis_tvalid     <= 1'b0;
      rx_axis_tlast      <= 1'b0;
      rx_axis_tuser      <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_bad_fcs   <= 1'b0;
      rx_good_frame      <= 1'b0;
    end else begin
      rx_axis_tvalid     <= 1'b0;
      rx_axis_tlast      <= 1'b0;
      rx_axis_tuser      <= 1'b0;
      rx_error_bad_frame <= 1'b0;
      rx_error_bad_fcs   <= 1'b0;
      rx_good_frame      <= 1'b0;
      if (frame_start) begin
        crc     <= CRC32_INIT;
        cnt     <= 11'd0;
        er_seen <= 1'b0;
        win     <= '0;
      end else if (byte_acc) begin
        crc     <= crc_nxt;
        cnt     <= (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
        er_seen <= er_seen | er_q;
        win     <= {win[2:0], rxd_q};
        if (cnt >= 11'd4) pend <= win[3];
        if (pend_vld) begin
          rx_axis_tdata  <= pend;
          rx_axis_tvalid <= 1'b1;
        end
      end else if (frame_end) begin
        if (pend_vld) begin
          rx_axis_tdata  <= pend;
          rx_axis_tvalid <= 1'b1;
          rx_axis_tlast  <= 1'b1;
          rx_axis_tuser  <= bad;
        end
        rx_error_bad_frame <= bad;
        rx_error_bad_fcs   <= fcs_bad;
        rx_good_frame      <= !bad;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed + randomized bench for gmii_rx_deframer against a frame-level reference model.
module tb_gmii_rx_deframer;

  typedef logic [7:0] bq_t[$];

  logic       clock125   = 1'b0;
  logic       reset      = 1'b1;
  logic [7:0] gmii_rxd   = 8'h00;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser;
  logic       rx_error_bad_frame, rx_error_bad_fcs, rx_good_frame;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_cyc = 0;
  int end_cyc = 0;

  logic [7:0] o_dat[$];
  logic       o_last[$];
  logic       o_user[$];
  int         o_cyc[$];
  int         o_stat_cyc[$];
  int         o_good = 0, o_bad = 0, o_fcs = 0;

  logic [7:0] e_dat[$];
  logic       e_last[$];
  logic       e_user[$];
  int         e_good = 0, e_bad = 0, e_fcs = 0;

  gmii_rx_deframer #(.MIN_FRAME_LENGTH(64), .MAX_FRAME_LENGTH(1522)) dut (
    .clock125           (clock125),
    .reset              (reset),
    .gmii_rxd           (gmii_rxd),
    .gmii_rx_dv         (gmii_rx_dv),
    .gmii_rx_er         (gmii_rx_er),
    .rx_axis_tdata      (rx_axis_tdata),
    .rx_axis_tvalid     (rx_axis_tvalid),
    .rx_axis_tlast      (rx_axis_tlast),
    .rx_axis_tuser      (rx_axis_tuser),
    .rx_error_bad_frame (rx_error_bad_frame),
    .rx_error_bad_fcs   (rx_error_bad_fcs),
    .rx_good_frame      (rx_good_frame)
  );

  always #4 clock125 = ~clock125;
  always @(posedge clock125) cyc <= cyc + 1;

  always @(negedge clock125) begin
    if (rx_axis_tvalid === 1'b1) begin
      o_dat.push_back(rx_axis_tdata);
      o_last.push_back(rx_axis_tlast);
      o_user.push_back(rx_axis_tuser);
      o_cyc.push_back(cyc);
    end
    if (rx_good_frame === 1'b1)      o_good++;
    if (rx_error_bad_frame === 1'b1) o_bad++;
    if (rx_error_bad_fcs === 1'b1)   o_fcs++;
    if (rx_good_frame === 1'b1 || rx_error_bad_frame === 1'b1) o_stat_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS value (complemented CRC-32 over the payload).
  function automatic logic [31:0] fcs32(input bq_t p);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      c ^= {24'd0, p[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p, input logic corrupt);
    bq_t b = p;
    logic [31:0] f = fcs32(p);
    for (int k = 0; k < 4; k++) b.push_back(f[8*k +: 8]);
    if (corrupt) b[p.size()] = b[p.size()] ^ 8'h01;
    return b;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  // Expected AXIS beats and status for one post-SFD byte sequence b.
  function automatic void expect_frame(input bq_t b, input logic er);
    int   n = b.size();
    logic fcs_ok, bad;
    bq_t  p;
    if (n >= 5) begin
      for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
      fcs_ok = (fcs32(p) == {b[n-1], b[n-2], b[n-3], b[n-4]});
      bad    = er || (n < 64) || (n > 1522) || !fcs_ok;
      foreach (p[i]) begin
        e_dat.push_back(p[i]);
        e_last.push_back(i == n - 5);
        e_user.push_back((i == n - 5) ? bad : 1'b0);
      end
      if (bad) e_bad++; else e_good++;
      if (!fcs_ok) e_fcs++;
    end else begin
      e_bad++;
      if (fcs32(b) != 32'h2144_DF1C) e_fcs++;
    end
  endfunction

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    @(posedge clock125);
    #1;
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input bq_t b, input int er_idx);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (b[i]) begin
      drive(b[i], 1'b1, i == er_idx);
      if (i == 0) first_cyc = cyc;
    end
    drive(8'h00, 1'b0, 1'b0);
    end_cyc = cyc;
  endtask

  task automatic clear_obs();
    o_dat.delete(); o_last.delete(); o_user.delete(); o_cyc.delete(); o_stat_cyc.delete();
    o_good = 0; o_bad = 0; o_fcs = 0;
  endtask

  task automatic compare(input string tag);
    int nd = 0, nl = 0, nu = 0;
    chk({tag, "_beats"}, o_dat.size(), e_dat.size());
    for (int i = 0; i < e_dat.size() && i < o_dat.size(); i++) begin
      if (o_dat[i] !== e_dat[i]) nd++;
      if (o_last[i] !== e_last[i]) nl++;
      if (e_last[i] && (o_user[i] !== e_user[i])) nu++;
    end
    chk({tag, "_data_mismatches"}, nd, 0);
    chk({tag, "_tlast_mismatches"}, nl, 0);
    chk({tag, "_tuser_mismatches"}, nu, 0);
    chk({tag, "_good"}, o_good, e_good);
    chk({tag, "_bad_frame"}, o_bad, e_bad);
    chk({tag, "_bad_fcs"}, o_fcs, e_fcs);
    clear_obs();
    e_dat.delete(); e_last.delete(); e_user.delete();
    e_good = 0; e_bad = 0; e_fcs = 0;
  endtask

  initial begin
    bq_t p, b, b2;
    int  len, er_idx, nl;
    logic corrupt;

    // Reset state
    repeat (3) @(posedge clock125);
    @(negedge clock125);
    chk("reset_outputs",
        {25'd0, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser,
         rx_error_bad_frame, rx_error_bad_fcs, rx_good_frame, 1'b0}, 32'd0);
    chk("reset_tdata", rx_axis_tdata, 8'h00);
    @(posedge clock125);
    #1 reset = 1'b0;
    idle(4);
    clear_obs();

    // Good minimum frame with latency checks
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    b = with_fcs(p, 1'b0);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    chk("min_first_latency", (o_cyc.size() > 0) ? o_cyc[0] - first_cyc : -1, 7);
    chk("min_continuity", (o_cyc.size() > 0) ? o_cyc[$] - o_cyc[0] : -1, 59);
    chk("min_tlast_latency", (o_cyc.size() > 0) ? o_cyc[$] - end_cyc : -1, 2);
    chk("min_status_latency", (o_stat_cyc.size() > 0) ? o_stat_cyc[0] - end_cyc : -1, 2);
    compare("min_good");

    // FCS error
    b = with_fcs(p, 1'b1);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    compare("fcs_err");

    // rx_er on payload byte 30
    p = rand_payload(60);
    b = with_fcs(p, 1'b0);
    send_frame(b, 30);
    expect_frame(b, 1'b1);
    idle(12);
    compare("rx_er");

    // Runt with valid FCS, then a 3-byte burst
    p = rand_payload(40);
    b = with_fcs(p, 1'b0);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    compare("runt40");
    b = rand_payload(3);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    compare("burst3");

    // Back-to-back good frames, single gap cycle
    b  = with_fcs(rand_payload(60), 1'b0);
    b2 = with_fcs(rand_payload(60), 1'b0);
    send_frame(b, -1);
    send_frame(b2, -1);
    expect_frame(b, 1'b0);
    expect_frame(b2, 1'b0);
    idle(12);
    compare("back_to_back");

    // Junk after preamble
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    idle(12);
    compare("junk");

    // Reset during payload byte 20
    b = with_fcs(rand_payload(60), 1'b0);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(b[i], 1'b1, 1'b0);
    drive(b[20], 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock125);
    chk("midrst_outputs",
        {17'd0, rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser,
         rx_error_bad_frame, rx_error_bad_fcs, rx_good_frame, 1'b0}, 32'd0);
    nl = 0;
    foreach (o_last[i]) if (o_last[i] === 1'b1) nl++;
    chk("midrst_no_tlast", nl, 0);
    chk("midrst_no_status", o_good + o_bad, 0);
    clear_obs();
    drive(b[21], 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 22; i < b.size(); i++) drive(b[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    idle(12);
    compare("midrst_tail");
    b = with_fcs(rand_payload(60), 1'b0);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    compare("after_reset");

    // Oversize frame is streamed in full and flagged
    b = with_fcs(rand_payload(1530), 1'b0);
    send_frame(b, -1);
    expect_frame(b, 1'b0);
    idle(12);
    compare("oversize");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      len     = $urandom_range(40, 140);
      corrupt = ($urandom_range(0, 3) == 0);
      er_idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      b = with_fcs(rand_payload(len), corrupt);
      send_frame(b, er_idx);
      expect_frame(b, er_idx >= 0);
      idle(12);
      compare($sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side GMII deframer for the 1G Ethernet path. It sits between a GMII receive interface and the AXI-Stream RX FIFO, running in the 125 MHz `clock125` domain. It strips the preamble/SFD, checks FCS, length and `rx_er`, and emits the payload without FCS as an 8-bit AXI-Stream with end-of-frame error flags. It is the GMII-to-AXIS counterpart of the MAC's TX framer and is used both as a loopback checker and as a standalone RX path.

## Interface
Parameters:
- `MIN_FRAME_LENGTH`, 64: minimum legal frame length in bytes, counted from the first byte after SFD and including FCS.
- `MAX_FRAME_LENGTH`, 1522: maximum legal length, counted the same way.

Ports:
- `clock125`  in  1  125 MHz clock; everything is in this domain.
- `reset`  in  1  reset, asynchronous and active-high.
- `gmii_rxd`  in  8  GMII receive data.
- `gmii_rx_dv`  in  1  GMII receive data valid.
- `gmii_rx_er`  in  1  GMII receive error.
- `rx_axis_tdata`  out  8  payload byte.
- `rx_axis_tvalid`  out  1  beat valid. There is no tready; the sink must accept every beat.
- `rx_axis_tlast`  out  1  last payload byte of the frame.
- `rx_axis_tuser`  out  1  bad-frame flag, meaningful only when tlast=1.
- `rx_error_bad_frame`  out  1  one-cycle pulse for any bad frame.
- `rx_error_bad_fcs`  out  1  one-cycle pulse when the FCS check failed.
- `rx_good_frame`  out  1  one-cycle pulse for a good frame.

## Operation
- **Input stage:** rxd, dv and er are registered once. All decisions below use the registered copies.
- **IDLE**
  - dv=1 and byte 0x55 → PREAMBLE.
  - dv=1 and byte 0xD5 → PAYLOAD.
  - dv=1 with any other byte → WAIT_END.
- **PREAMBLE**
  - 0x55 → stay.
  - 0xD5 → PAYLOAD.
  - Any other byte → WAIT_END.
  - dv=0 → IDLE.
  - None of these exits produces output or status.
- **PAYLOAD entry:** CRC is set to 0xFFFFFFFF, the 11-bit byte count is cleared, the er-seen flag is cleared, and the delay line is emptied.
- **PAYLOAD, each byte with dv=1**
  - CRC is updated (reflected CRC-32, poly 0x04C11DB7, LSB-first).
  - The count increments, saturating at 2047.
  - er-seen |= er.
  - The byte enters a 4-byte FCS window. The byte leaving the window moves into a one-byte pending register.
  - If pending was already valid, its old value is emitted first with tlast=0, tuser=0.
- **PAYLOAD, dv falls**
  - If pending is valid, it is emitted with tlast=1.
  - bad = er-seen OR count<MIN_FRAME_LENGTH OR count>MAX_FRAME_LENGTH OR CRC≠0xDEBB20E3.
  - tuser=bad. The status pulses fire in the same cycle as tlast.
  - rx_error_bad_fcs fires iff the CRC residue mismatched.
  - rx_good_frame fires iff not bad. rx_error_bad_frame fires iff bad.
  - If pending never filled (fewer than 5 bytes after SFD): no AXIS beat is emitted, and rx_error_bad_frame pulses (plus rx_error_bad_fcs if the residue mismatched).
  - State → IDLE.
- **WAIT_END:** stay until dv=0, then → IDLE.
- **Oversize frames:** bytes keep streaming; the frame is flagged at tlast via tuser=1. It is not truncated.

## Timing
- **Reset values:** every output is 0; state=IDLE; pending and window are empty.
- **Reset mid-frame:** the partial frame is abandoned with no tlast. After release, if dv=1 the block enters WAIT_END and skips the rest of that frame.
- **Payload latency:** a payload byte on `gmii_rxd` in cycle t appears on `rx_axis_tdata` in cycle t+7, under continuous dv.
- **End-of-frame latency:** if the first dv=0 cycle on the pins is T, then tlast and the status pulses appear in cycle T+2.
- **Continuity:** within a frame, tvalid is continuous while dv is continuous.
- **Back-to-back frames:** a single dv=0 gap cycle between frames must be handled. The tlast of frame N and the preamble of frame N+1 may overlap in time, and the two frames must not merge.
- **Count width:** 11 bits, saturating; the comparisons use the saturated value.

## Structure
- **Package `eth_pkg` contents:**
  - `ETH_PREAMBLE`=0x55, `ETH_SFD`=0xD5.
  - `CRC32_INIT`=0xFFFFFFFF, `CRC32_RESIDUE`=0xDEBB20E3.
  - State enum IDLE/PREAMBLE/PAYLOAD/WAIT_END.
- **Sub-module `crc32_d8`:** combinational 8-bit-per-step CRC-32 next-state function (crc_in, data → crc_out). It is shared with the TX framer.

## Test plan
1. **Good minimum frame:** 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS → 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, rx_good_frame pulses once, first beat 7 cycles after 0x00 on the pins.
2. **FCS error:** same frame with the first FCS byte XOR 0x01 → 60 beats, tuser=1 at tlast, rx_error_bad_frame and rx_error_bad_fcs pulse, no good pulse.
3. **rx_er mid-payload:** gmii_rx_er=1 for one cycle on payload byte 30, correct FCS → tuser=1, bad_frame pulses, bad_fcs stays 0.
4. **Runt:** 40-byte payload with valid FCS (count=44) → 40 beats, tuser=1, bad_frame only. A 3-byte post-SFD burst → no beats, bad_frame pulses.
5. **Back-to-back and junk:**
   - Two good 64-byte frames with a 1-cycle dv gap → two tlasts, 120 beats total, two good pulses.
   - dv high with 0x55×7 then 0x12 → no output, no status.
6. **Reset mid-frame:** assert reset during payload byte 20 → all outputs 0 the next cycle, no tlast. Hold dv through the remaining bytes → ignored. A following good frame is received correctly.
